// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: the instruction-queue entry and its default depth.
package cpu_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } iq_entry_t;

  localparam int IQ_DEPTH_DEFAULT = 16;
endpackage

// File: rtl/inst_queue_ram.sv
// Instruction-queue storage: two write ports, two async read ports, no reset.
// Write ports never target the same entry in one cycle (consecutive addresses).
module inst_queue_ram
  import cpu_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  iq_entry_t                wdata1,
  input  logic                     we2,
  input  logic [$clog2(DEPTH)-1:0] waddr2,
  input  iq_entry_t                wdata2,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  input  logic [$clog2(DEPTH)-1:0] raddr2,
  output iq_entry_t                rdata1,
  output iq_entry_t                rdata2
);
  iq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we1) mem[waddr1] <= wdata1;
    if (we2) mem[waddr2] <= wdata2;
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between fetch and decode: pushes/pops 0-2 words per cycle in order,
// 1-cycle push-to-head latency (same cycle when INST_QUEUE_BYPASS_EN and empty); fetch stalls on full.
module inst_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push_en1,
  input  logic        push_en2,
  input  logic [31:0] push_pc1,
  input  logic [31:0] push_pc2,
  input  logic [31:0] push_instr1,
  input  logic [31:0] push_instr2,
  input  logic        pop_master,
  input  logic        pop_slave,
  output logic        master_valid,
  output logic [31:0] master_pc,
  output logic [31:0] master_instr,
  output logic        slave_valid,
  output logic [31:0] slave_pc,
  output logic [31:0] slave_instr,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          primed;  // storage holds no written data until the first push after reset
  iq_entry_t     word1, word2, rd_head, rd_next, wdata1, head, next;
  logic [1:0]    n_push, n_pop, n_store, n_deq;
  logic          bypass, we1, we2;

  assign word1 = iq_entry_t'{pc: push_pc1, instr: push_instr1};
  assign word2 = iq_entry_t'{pc: push_pc2, instr: push_instr2};

  always_comb begin
    full   = count > (AW+1)'(DEPTH-2);
    empty  = count == '0;
    n_push = 2'd0;
    if (!full && push_en1) n_push = push_en2 ? 2'd2 : 2'd1;
`ifdef INST_QUEUE_BYPASS_EN
    bypass = empty && !flush;
`else
    bypass = 1'b0;
`endif
    // When bypassing, pops consume the incoming words instead of stored ones.
    n_pop = 2'd0;
    if (pop_master && (bypass ? (n_push != 2'd0) : (count != '0)))
      n_pop = (pop_slave && (bypass ? (n_push == 2'd2) : (count >= (AW+1)'(2)))) ? 2'd2 : 2'd1;
    n_store = bypass ? (n_push - n_pop) : n_push;
    n_deq   = bypass ? 2'd0 : n_pop;
    we1     = !flush && (n_store != 2'd0);
    we2     = !flush && (n_store == 2'd2);
    wdata1  = (bypass && n_pop == 2'd1) ? word2 : word1;
  end

  inst_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .we1    (we1),
    .waddr1 (wr_ptr),
    .wdata1 (wdata1),
    .we2    (we2),
    .waddr2 (wr_ptr + AW'(1)),
    .wdata2 (word2),
    .raddr1 (rd_ptr),
    .raddr2 (rd_ptr + AW'(1)),
    .rdata1 (rd_head),
    .rdata2 (rd_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      primed <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_store);
      rd_ptr <= rd_ptr + AW'(n_deq);
      count  <= count + (AW+1)'(n_store) - (AW+1)'(n_deq);
      if (we1) primed <= 1'b1;
    end
  end

  always_comb begin
    head = primed ? rd_head : '0;
    next = primed ? rd_next : '0;
    master_valid = count >= (AW+1)'(1);
    slave_valid  = count >= (AW+1)'(2);
    if (bypass) begin
      head         = word1;
      next         = word2;
      master_valid = push_en1;
      slave_valid  = push_en1 && push_en2;
    end
    master_pc    = head.pc;
    master_instr = head.instr;
    slave_pc     = next.pc;
    slave_instr  = next.instr;
  end
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue; default build, or bypass build with INST_QUEUE_BYPASS_EN.
module tb_inst_queue;
  import cpu_pkg::*;

  localparam logic [31:0] K = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst, flush, push_en1, push_en2, pop_master, pop_slave;
  logic [31:0] push_pc1, push_pc2, push_instr1, push_instr2;
  logic        master_valid, slave_valid, full, empty;
  logic [31:0] master_pc, master_instr, slave_pc, slave_instr;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pc;

  inst_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_en1(push_en1), .push_en2(push_en2),
    .push_pc1(push_pc1), .push_pc2(push_pc2),
    .push_instr1(push_instr1), .push_instr2(push_instr2),
    .pop_master(pop_master), .pop_slave(pop_slave),
    .master_valid(master_valid), .master_pc(master_pc), .master_instr(master_instr),
    .slave_valid(slave_valid), .slave_pc(slave_pc), .slave_instr(slave_instr),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input int n, input logic [31:0] pc0);
    push_en1    = (n >= 1);
    push_en2    = (n >= 2);
    push_pc1    = pc0;
    push_instr1 = pc0 ^ K;
    push_pc2    = pc0 + 32'd4;
    push_instr2 = (pc0 + 32'd4) ^ K;
  endtask

  task automatic idle();
    drive_push(0, 32'h0);
    pop_master = 1'b0;
    pop_slave  = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // 1: reset
    repeat (2) cyc();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_mv", 32'(master_valid), 32'd0);
    chk("rst_sv", 32'(slave_valid), 32'd0);
    chk("rst_count", 32'(dut.count), 32'd0);
    chk("rst_mpc", master_pc, 32'd0);
    rst = 1'b0;

    // 2: fill with pairs, no pop; full asserts only with fewer than 2 free entries
    pc = 32'hBFC0_0000;
    for (int i = 0; i < 7; i++) begin
      drive_push(2, pc);
      pc += 32'd8;
      cyc();
    end
    idle();
    #1;
    chk("fill14_count", 32'(dut.count), 32'd14);
    chk("fill14_full", 32'(full), 32'd0);
    chk("fill_mpc", master_pc, 32'hBFC0_0000);
    chk("fill_spc", slave_pc, 32'hBFC0_0004);
    chk("fill_minstr", master_instr, 32'hBFC0_0000 ^ K);
    drive_push(2, pc);
    cyc();
    chk("fill16_count", 32'(dut.count), 32'd16);
    chk("fill16_full", 32'(full), 32'd1);
    drive_push(2, 32'hDEAD_0000);
    cyc();
    idle();
    chk("full_ignored", 32'(dut.count), 32'd16);
    chk("full_mpc", master_pc, 32'hBFC0_0000);

    // mid-traffic reset discards everything
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_count", 32'(dut.count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);

    // 3: steady push2/pop2 at count 4 across pointer wrap
    pc = 32'h0000_1000;
    for (int i = 0; i < 2; i++) begin
      drive_push(2, pc);
      exp_q.push_back(pc);
      exp_q.push_back(pc + 32'd4);
      pc += 32'd8;
      cyc();
    end
    for (int i = 0; i < 20; i++) begin
      drive_push(2, pc);
      pop_master = 1'b1;
      pop_slave  = 1'b1;
      #1;
      chk("wrap_mpc", master_pc, exp_q[0]);
      chk("wrap_spc", slave_pc, exp_q[1]);
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      exp_q.push_back(pc);
      exp_q.push_back(pc + 32'd4);
      pc += 32'd8;
      cyc();
    end
    idle();
    chk("wrap_count", 32'(dut.count), 32'd4);
    chk("wrap_wrptr", 32'(dut.wr_ptr), 32'd12);
    chk("wrap_head", master_pc, exp_q[0]);

    // 4: pop clamping
    pop_master = 1'b1;
    pop_slave  = 1'b1;
    cyc();
    pop_slave = 1'b0;
    cyc();
    chk("c1_count", 32'(dut.count), 32'd1);
    chk("c1_sv", 32'(slave_valid), 32'd0);
    chk("c1_mpc", master_pc, exp_q[3]);
    pop_slave = 1'b1;
    cyc();
    idle();
    chk("overpop_count", 32'(dut.count), 32'd0);
    chk("overpop_empty", 32'(empty), 32'd1);
    drive_push(1, 32'h0000_2000);
    cyc();
    idle();
    pop_slave = 1'b1;
    cyc();
    idle();
    chk("slaveonly_count", 32'(dut.count), 32'd1);
    chk("slaveonly_mpc", master_pc, 32'h0000_2000);

    // 5: flush beats same-cycle push/pop
    pc = 32'h0000_3000;
    for (int i = 0; i < 4; i++) begin
      drive_push(2, pc);
      pc += 32'd8;
      cyc();
    end
    idle();
    chk("pre_flush_count", 32'(dut.count), 32'd9);
    flush = 1'b1;
    drive_push(2, 32'h0000_4000);
    pop_master = 1'b1;
    cyc();
    idle();
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_mv", 32'(master_valid), 32'd0);
    chk("flush_sv", 32'(slave_valid), 32'd0);
    chk("flush_count", 32'(dut.count), 32'd0);
    cyc();
    chk("flush_stay", 32'(dut.count), 32'd0);

    // 6: push2 + pop_master into an empty queue
    drive_push(2, 32'h0000_5000);
    pop_master = 1'b1;
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_mv", 32'(master_valid), 32'd1);
    chk("byp_minstr", master_instr, 32'h0000_5000 ^ K);
    chk("byp_sv", 32'(slave_valid), 32'd1);
    cyc();
    idle();
    chk("byp_count", 32'(dut.count), 32'd1);
    chk("byp_next_minstr", master_instr, 32'h0000_5004 ^ K);
`else
    chk("nobyp_mv", 32'(master_valid), 32'd0);
    cyc();
    idle();
    chk("nobyp_count", 32'(dut.count), 32'd2);
    chk("nobyp_minstr", master_instr, 32'h0000_5000 ^ K);
    chk("nobyp_sinstr", slave_instr, 32'h0000_5004 ^ K);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
